// File: rtl/aes_ct_serializer.sv
// AES ciphertext capture buffer and word serializer; optional blk_cnt port under AES_CT_BLKCNT_EN.
// Latency: capture LATENCY cycles after en_start, first word valid the cycle after capture.
// Backpressure: out_ready=0 holds the current word; a capture into a full buffer is dropped and sets ovf.
module aes_ct_serializer #(
    parameter int LATENCY = 1,
    parameter int WORD_W  = 32,
    parameter int DEPTH   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_start,
    input  logic [127:0]      ciphertext_i,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic              full,
    output logic              ovf,
    input  logic              ovf_clr
`ifdef AES_CT_BLKCNT_EN
    ,
    output logic [15:0]       blk_cnt
`endif
);

    localparam int NW = 128 / WORD_W;
    localparam int WW = (NW > 1) ? $clog2(NW) : 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
    localparam logic [WW-1:0] WIDX_LAST = WW'(NW - 1);

    typedef enum logic {IDLE, SEND} state_t;

    logic          cap;
    logic [127:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [WW-1:0] widx_q, widx_d;
    state_t        state_q, state_d;
    logic          full_q, full_d, ovf_q, ovf_d;
    logic          fire, retire, accept, drop;
    logic [127:0]  shifted;

    // cap tracks the core's pipeline so ciphertext_i is sampled when valid.
    generate
        if (LATENCY == 0) begin : g_nodly
            assign cap = en_start;
        end else begin : g_dly
            logic [LATENCY-1:0] dly_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) dly_q <= '0;
                else      dly_q <= (dly_q << 1) | LATENCY'(en_start);
            end
            assign cap = dly_q[LATENCY-1];
        end
    endgenerate

    always_comb begin
        shifted   = mem_q[rd_ptr_q] >> (WORD_W * (NW - 1 - int'(widx_q)));
        out_valid = (state_q == SEND);
        out_last  = out_valid & (widx_q == WIDX_LAST);
        out_data  = out_valid ? shifted[WORD_W-1:0] : '0;
        fire      = out_valid & out_ready;
        retire    = fire & out_last;
        // A retiring head frees its slot in the same cycle, so a full buffer can still accept.
        accept    = cap & ((count_q != DEPTH_C) | retire);
        drop      = cap & ~accept;
        count_d   = count_q + CW'(accept) - CW'(retire);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (accept) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        if (retire) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        widx_d    = widx_q;
        if (fire) widx_d = out_last ? '0 : widx_q + 1'b1;
        full_d    = (count_d == DEPTH_C);
        ovf_d     = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
        state_d   = state_q;
        case (state_q)
            IDLE:    if (count_d != '0) state_d = SEND;
            SEND:    if (retire && count_d == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            widx_q   <= '0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            widx_q   <= widx_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_ptr_q] <= ciphertext_i;
    end

    assign full = full_q;
    assign ovf  = ovf_q;

`ifdef AES_CT_BLKCNT_EN
    logic [15:0] blk_cnt_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        blk_cnt_q <= '0;
        else if (retire) blk_cnt_q <= blk_cnt_q + 16'd1;
    end
    assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_aes_ct_serializer.sv
// Directed bench for aes_ct_serializer (LATENCY=1, WORD_W=32, DEPTH=2).
module tb_aes_ct_serializer;

    logic         clk = 1'b0;
    logic         rst;
    logic         en_start;
    logic [127:0] ciphertext_i;
    logic         out_ready;
    logic         out_valid;
    logic [31:0]  out_data;
    logic         out_last;
    logic         full;
    logic         ovf;
    logic         ovf_clr;
`ifdef AES_CT_BLKCNT_EN
    logic [15:0]  blk_cnt;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] BA = 128'h0000000a_0000000b_0000000c_0000000d;
    localparam logic [127:0] BB = 128'h1111111a_1111111b_1111111c_1111111d;
    localparam logic [127:0] BC = 128'h2222222a_2222222b_2222222c_2222222d;

    aes_ct_serializer #(.LATENCY(1), .WORD_W(32), .DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .en_start     (en_start),
        .ciphertext_i (ciphertext_i),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_last     (out_last),
        .full         (full),
        .ovf          (ovf),
        .ovf_clr      (ovf_clr)
`ifdef AES_CT_BLKCNT_EN
        ,
        .blk_cnt      (blk_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [31:0] d, input logic l);
        chk({tag, "_vld"}, 128'(out_valid), 128'(1'b1));
        chk({tag, "_dat"}, 128'(out_data), 128'(d));
        chk({tag, "_last"}, 128'(out_last), 128'(l));
    endtask

    // Checks one whole block leaving MSB word first, one word per cycle (out_ready high).
    task automatic send_blk(input string tag, input logic [127:0] b);
        logic [127:0] v;
        v = b;
        for (int i = 0; i < 4; i++) begin
            chk_word($sformatf("%s_w%0d", tag, i), v[127-32*i -: 32], i == 3);
            tick();
        end
    endtask

    task automatic capture(input logic [127:0] b);
        en_start = 1'b1;
        tick();
        en_start = 1'b0;
        ciphertext_i = b;
        tick();
    endtask

    initial begin
        rst = 1'b0; en_start = 1'b0; ciphertext_i = '0; out_ready = 1'b0; ovf_clr = 1'b0;
        tick(); tick();
        chk("rst_vld",  128'(out_valid), 128'(1'b0));
        chk("rst_dat",  128'(out_data),  128'(32'h0));
        chk("rst_last", 128'(out_last),  128'(1'b0));
        chk("rst_full", 128'(full),      128'(1'b0));
        chk("rst_ovf",  128'(ovf),       128'(1'b0));
        rst = 1'b1;
        tick();

        // Single block, continuous ready.
        out_ready = 1'b1;
        en_start = 1'b1;
        tick();
        en_start = 1'b0;
        ciphertext_i = CT;
        chk("t1_c1_vld", 128'(out_valid), 128'(1'b0));
        tick();
        chk_word("t1_w0", 32'h69c4e0d8, 1'b0); tick();
        chk_word("t1_w1", 32'h6a7b0430, 1'b0); tick();
        chk_word("t1_w2", 32'hd8cdb780, 1'b0); tick();
        chk_word("t1_w3", 32'h70b4c55a, 1'b1);
        chk("t1_ovf", 128'(ovf), 128'(1'b0));
        tick();
        chk("t1_idle", 128'(out_valid), 128'(1'b0));

        // Backpressure on the second word.
        capture(CT);
        chk_word("t2_w0", 32'h69c4e0d8, 1'b0); tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_word($sformatf("t2_hold%0d", i), 32'h6a7b0430, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        chk_word("t2_w1", 32'h6a7b0430, 1'b0); tick();
        chk_word("t2_w2", 32'hd8cdb780, 1'b0); tick();
        chk_word("t2_w3", 32'h70b4c55a, 1'b1); tick();
        chk("t2_idle", 128'(out_valid), 128'(1'b0));

        // Overflow: three back-to-back captures while stalled.
        out_ready = 1'b0;
        en_start = 1'b1; tick();
        ciphertext_i = 128'h1; tick();
        ciphertext_i = 128'h2; tick();
        en_start = 1'b0; ciphertext_i = 128'h3;
        chk("t3_full", 128'(full), 128'(1'b1));
        chk("t3_ovf0", 128'(ovf),  128'(1'b0));
        tick();
        chk("t3_ovf1", 128'(ovf),  128'(1'b1));
        chk("t3_full2", 128'(full), 128'(1'b1));
        out_ready = 1'b1;
        send_blk("t3_A", 128'h1);
        send_blk("t3_B", 128'h2);
        chk("t3_idle", 128'(out_valid), 128'(1'b0));
        chk("t3_full0", 128'(full), 128'(1'b0));
        chk("t3_ovf_sticky", 128'(ovf), 128'(1'b1));
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("t3_ovf_clr", 128'(ovf), 128'(1'b0));

        // Full buffer with a capture landing on the head's last-word accept.
        out_ready = 1'b0;
        en_start = 1'b1; tick();
        ciphertext_i = BA; tick();
        en_start = 1'b0; ciphertext_i = BB; tick();
        chk("t4_full", 128'(full), 128'(1'b1));
        out_ready = 1'b1;
        chk_word("t4_A_w0", 32'h0000000a, 1'b0); tick();
        chk_word("t4_A_w1", 32'h0000000b, 1'b0); tick();
        en_start = 1'b1;
        chk_word("t4_A_w2", 32'h0000000c, 1'b0); tick();
        en_start = 1'b0; ciphertext_i = BC;
        chk_word("t4_A_w3", 32'h0000000d, 1'b1); tick();
        chk("t4_full_kept", 128'(full), 128'(1'b1));
        send_blk("t4_B", BB);
        send_blk("t4_C", BC);
        chk("t4_idle", 128'(out_valid), 128'(1'b0));
        chk("t4_ovf", 128'(ovf), 128'(1'b0));

        // Asynchronous reset in the middle of a block.
        capture(BB);
        chk_word("t5_w0", 32'h1111111a, 1'b0); tick();
        chk_word("t5_w1", 32'h1111111b, 1'b0); tick();
        rst = 1'b0;
        #1;
        chk("t5_rst_vld",  128'(out_valid), 128'(1'b0));
        chk("t5_rst_dat",  128'(out_data),  128'(32'h0));
        chk("t5_rst_last", 128'(out_last),  128'(1'b0));
        chk("t5_rst_full", 128'(full),      128'(1'b0));
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t5_quiet%0d", i), 128'(out_valid), 128'(1'b0));
        end
        capture(BC);
        send_blk("t5_new", BC);
        chk("t5_idle", 128'(out_valid), 128'(1'b0));

`ifdef AES_CT_BLKCNT_EN
        rst = 1'b0; tick(); rst = 1'b1; tick();
        chk("t6_cnt0", 128'(blk_cnt), 128'(16'd0));
        for (int i = 0; i < 3; i++) begin
            capture(BA);
            send_blk($sformatf("t6_b%0d", i), BA);
        end
        chk("t6_cnt3", 128'(blk_cnt), 128'(16'd3));
        force dut.blk_cnt_q = 16'hFFFF;
        tick();
        release dut.blk_cnt_q;
        tick();
        chk("t6_cntffff", 128'(blk_cnt), 128'(16'hFFFF));
        capture(BB);
        send_blk("t6_wrap", BB);
        chk("t6_cntwrap", 128'(blk_cnt), 128'(16'd0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
